// File: rtl/vx_evict_buffer.sv
// ---------------------------------------------------------------------------
// vx_evict_buffer
// Small FIFO that holds dirty lines evicted from a cache bank until memory
// accepts the write-back. Lines with an all-zero dirty mask are accepted but
// dropped, so they never reach memory. A combinational snoop port lets the
// fill path see whether a line address is still waiting in the buffer.
//
// Ports
//   clk, reset          : clock and synchronous active-high reset
//   evict_valid/ready   : eviction handshake (ready = buffer not full)
//   evict_addr/data/    : line address, line data, per-byte dirty mask
//   evict_dirtyb
//   mem_req_valid/ready : write request handshake toward memory
//   mem_req_rw          : always 1 (write)
//   mem_req_addr/       : head entry address, byte enables and data
//   mem_req_byteen/data
//   snoop_addr/hit      : address probe and hit flag (combinational)
//   empty, count        : occupancy status
// ---------------------------------------------------------------------------
module vx_evict_buffer #(
   parameter int CACHE_LINE_SIZE = 64,
   parameter int LINE_ADDR_WIDTH = 26,
   parameter int DEPTH           = 4
) (
   input  logic                         clk,
   input  logic                         reset,

   input  logic                         evict_valid,
   input  logic [LINE_ADDR_WIDTH-1:0]   evict_addr,
   input  logic [CACHE_LINE_SIZE*8-1:0] evict_data,
   input  logic [CACHE_LINE_SIZE-1:0]   evict_dirtyb,
   output logic                         evict_ready,

   output logic                         mem_req_valid,
   output logic                         mem_req_rw,
   output logic [LINE_ADDR_WIDTH-1:0]   mem_req_addr,
   output logic [CACHE_LINE_SIZE-1:0]   mem_req_byteen,
   output logic [CACHE_LINE_SIZE*8-1:0] mem_req_data,
   input  logic                         mem_req_ready,

   input  logic [LINE_ADDR_WIDTH-1:0]   snoop_addr,
   output logic                         snoop_hit,

   output logic                         empty,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int DATA_W = CACHE_LINE_SIZE * 8;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("vx_evict_buffer: DEPTH must be a power of two and at least 2");
   end

   // Payload storage is never reset; r_valid tracks which slots are live.
   logic [LINE_ADDR_WIDTH-1:0] r_addr [DEPTH];
   logic [DATA_W-1:0]          r_data [DEPTH];
   logic [CACHE_LINE_SIZE-1:0] r_mask [DEPTH];
   logic [DEPTH-1:0]           r_valid;

   logic [PTR_W-1:0]           r_head;
   logic [PTR_W-1:0]           r_tail;
   logic [CNT_W-1:0]           r_count;

   logic                       w_full;
   logic                       w_push;
   logic                       w_store;
   logic                       w_pop;
   logic                       w_snoop_hit;

   // No bypass: a full buffer refuses a push even if the head pops this cycle.
   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_push  = evict_valid && !w_full && !reset;
   // A clean line completes the handshake but occupies no slot.
   assign w_store = w_push && (|evict_dirtyb);
   assign w_pop   = (r_count != '0) && mem_req_ready && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else begin
         // Push and pop never target the same slot: push needs a free slot,
         // pop needs a live one, and the two pointers only meet when the
         // buffer is completely full or completely empty.
         if (w_store) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + 1'b1;
         end
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + 1'b1;
         end
         if (w_store && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_store) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_store) begin
         r_addr[r_tail] <= evict_addr;
         r_data[r_tail] <= evict_data;
         r_mask[r_tail] <= evict_dirtyb;
      end
   end

   // Snoop looks at pre-edge contents, so a line popping this cycle still hits
   // and a line being pushed this cycle does not yet.
   always_comb begin
      w_snoop_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && (r_addr[i] == snoop_addr)) begin
            w_snoop_hit = 1'b1;
         end
      end
   end

   assign evict_ready    = !w_full;
   assign mem_req_valid  = (r_count != '0);
   assign mem_req_rw     = 1'b1;
   assign mem_req_addr   = r_addr[r_head];
   assign mem_req_byteen = r_mask[r_head];
   assign mem_req_data   = r_data[r_head];
   assign snoop_hit      = w_snoop_hit;
   assign empty          = (r_count == '0);
   assign count          = r_count;

endmodule

// File: tb/tb_vx_evict_buffer.sv
// ---------------------------------------------------------------------------
// tb_vx_evict_buffer
// Scenario tasks drive evictions and memory back-pressure; every stored line
// is queued as an expected write and a monitor compares each memory
// handshake against the queue head.
// ---------------------------------------------------------------------------
module tb_vx_evict_buffer;

   localparam int CLS   = 64;
   localparam int AW    = 26;
   localparam int DEPTH = 4;
   localparam int DW    = CLS * 8;

   typedef struct {
      logic [AW-1:0]  addr;
      logic [DW-1:0]  data;
      logic [CLS-1:0] mask;
   } entry_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            evict_valid;
   logic [AW-1:0]   evict_addr;
   logic [DW-1:0]   evict_data;
   logic [CLS-1:0]  evict_dirtyb;
   logic            evict_ready;
   logic            mem_req_valid;
   logic            mem_req_rw;
   logic [AW-1:0]   mem_req_addr;
   logic [CLS-1:0]  mem_req_byteen;
   logic [DW-1:0]   mem_req_data;
   logic            mem_req_ready;
   logic [AW-1:0]   snoop_addr;
   logic            snoop_hit;
   logic            empty;
   logic [$clog2(DEPTH):0] count;

   int     errors = 0;
   int     checks = 0;
   entry_t exp_q[$];

   vx_evict_buffer #(
      .CACHE_LINE_SIZE(CLS),
      .LINE_ADDR_WIDTH(AW),
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .evict_valid(evict_valid),
      .evict_addr(evict_addr),
      .evict_data(evict_data),
      .evict_dirtyb(evict_dirtyb),
      .evict_ready(evict_ready),
      .mem_req_valid(mem_req_valid),
      .mem_req_rw(mem_req_rw),
      .mem_req_addr(mem_req_addr),
      .mem_req_byteen(mem_req_byteen),
      .mem_req_data(mem_req_data),
      .mem_req_ready(mem_req_ready),
      .snoop_addr(snoop_addr),
      .snoop_hit(snoop_hit),
      .empty(empty),
      .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
      return {16{6'h2A, a}};
   endfunction

   // Inputs change 1 time unit after the rising edge; outputs are read on the
   // falling edge, where a handshake seen now will fire at the next edge.
   always @(negedge clk) begin
      if (mem_req_valid && mem_req_ready && !reset) begin
         entry_t e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=%h, expected no write", mem_req_addr);
         end else begin
            e = exp_q.pop_front();
            if (mem_req_addr !== e.addr || mem_req_byteen !== e.mask ||
                mem_req_data !== e.data || mem_req_rw !== 1'b1) begin
               errors++;
               $display("FAIL write_order: got addr=%h mask=%h rw=%b, expected addr=%h mask=%h rw=1",
                        mem_req_addr, mem_req_byteen, mem_req_rw, e.addr, e.mask);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Offers one eviction for one cycle; queues it if it will be stored.
   task automatic push(input logic [AW-1:0] a, input logic [CLS-1:0] m);
      entry_t e;
      evict_valid  = 1'b1;
      evict_addr   = a;
      evict_data   = mk_data(a);
      evict_dirtyb = m;
      if (evict_ready && m != '0) begin
         e.addr = a;
         e.data = mk_data(a);
         e.mask = m;
         exp_q.push_back(e);
      end
      cyc();
      evict_valid = 1'b0;
   endtask

   task automatic drain();
      mem_req_ready = 1'b1;
      for (int i = 0; i < 40 && !empty; i++) cyc();
      mem_req_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (empty !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got empty=%b pending=%0d, expected empty=1 pending=0",
                  empty, exp_q.size());
      end
      cyc();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      evict_valid = 1'b0;
      evict_addr = '0;
      evict_data = '0;
      evict_dirtyb = '0;
      mem_req_ready = 1'b0;
      snoop_addr = '0;
      cyc();
      cyc();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (count !== 0 || empty !== 1'b1 || mem_req_valid !== 1'b0 ||
          evict_ready !== 1'b1 || snoop_hit !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got count=%0d empty=%b valid=%b ready=%b hit=%b, expected 0 1 0 1 0",
                  count, empty, mem_req_valid, evict_ready, snoop_hit);
      end
      cyc();
   endtask

   task automatic test_basic_push();
      push(26'h10, 64'hF);
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 26'h10 || mem_req_byteen !== 64'hF ||
          mem_req_data !== mk_data(26'h10) || count !== 1) begin
         errors++;
         $display("FAIL basic_push: got valid=%b addr=%h mask=%h count=%0d, expected 1 10 f 1",
                  mem_req_valid, mem_req_addr, mem_req_byteen, count);
      end
      cyc();
      drain();
   endtask

   task automatic test_zero_mask();
      evict_valid = 1'b1;
      evict_addr = 26'h20;
      evict_data = mk_data(26'h20);
      evict_dirtyb = '0;
      @(negedge clk);
      checks++;
      if (evict_ready !== 1'b1) begin
         errors++;
         $display("FAIL zero_mask_ready: got %b, expected 1", evict_ready);
      end
      cyc();
      evict_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (count !== 0 || mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL zero_mask_drop: got count=%0d valid=%b, expected 0 0", count, mem_req_valid);
      end
      cyc();
   endtask

   task automatic test_fill_drain();
      mem_req_ready = 1'b0;
      for (int i = 1; i <= DEPTH; i++) push(AW'(i), 64'hFF << i);
      @(negedge clk);
      checks++;
      if (count !== DEPTH || evict_ready !== 1'b0 || mem_req_addr !== 26'h1) begin
         errors++;
         $display("FAIL full: got count=%0d ready=%b head=%h, expected 4 0 1",
                  count, evict_ready, mem_req_addr);
      end
      cyc();
      push(26'h5, 64'h3);
      @(negedge clk);
      checks++;
      if (count !== DEPTH) begin
         errors++;
         $display("FAIL push_when_full: got count=%0d, expected 4", count);
      end
      cyc();
      drain();
      // Pointers have wrapped; duplicates must still issue independently.
      push(26'h50, 64'h1);
      push(26'h50, 64'h2);
      push(26'h51, 64'h4);
      @(negedge clk);
      checks++;
      if (count !== 3) begin
         errors++;
         $display("FAIL dup_count: got count=%0d, expected 3", count);
      end
      cyc();
      drain();
   endtask

   task automatic test_simultaneous();
      push(26'h30, 64'hF0);
      mem_req_ready = 1'b1;
      push(26'h31, 64'h0F);
      mem_req_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (count !== 1 || mem_req_addr !== 26'h31 || mem_req_byteen !== 64'h0F) begin
         errors++;
         $display("FAIL push_pop_same_cycle: got count=%0d head=%h mask=%h, expected 1 31 0f",
                  count, mem_req_addr, mem_req_byteen);
      end
      cyc();
      drain();
   endtask

   task automatic test_snoop();
      push(26'h40, 64'h1);
      push(26'h41, 64'h3);
      snoop_addr = 26'h41;
      @(negedge clk);
      checks++;
      if (snoop_hit !== 1'b1) begin
         errors++;
         $display("FAIL snoop_hit_41: got %b, expected 1", snoop_hit);
      end
      snoop_addr = 26'h42;
      #1;
      checks++;
      if (snoop_hit !== 1'b0) begin
         errors++;
         $display("FAIL snoop_miss_42: got %b, expected 0", snoop_hit);
      end
      snoop_addr = 26'h40;
      #1;
      checks++;
      if (snoop_hit !== 1'b1) begin
         errors++;
         $display("FAIL snoop_hit_40: got %b, expected 1", snoop_hit);
      end
      cyc();
      drain();
      snoop_addr = 26'h41;
      @(negedge clk);
      checks++;
      if (snoop_hit !== 1'b0) begin
         errors++;
         $display("FAIL snoop_after_pop: got %b, expected 0", snoop_hit);
      end
      cyc();
   endtask

   task automatic test_mid_reset();
      push(26'h60, 64'h1);
      push(26'h61, 64'h1);
      push(26'h62, 64'h1);
      @(negedge clk);
      checks++;
      if (count !== 3) begin
         errors++;
         $display("FAIL pre_reset_count: got %0d, expected 3", count);
      end
      cyc();
      reset = 1'b1;
      evict_valid = 1'b1;
      evict_addr = 26'h63;
      evict_data = mk_data(26'h63);
      evict_dirtyb = 64'hF;
      mem_req_ready = 1'b1;
      exp_q.delete();
      cyc();
      reset = 1'b0;
      evict_valid = 1'b0;
      mem_req_ready = 1'b0;
      snoop_addr = 26'h60;
      @(negedge clk);
      checks++;
      if (count !== 0 || mem_req_valid !== 1'b0 || evict_ready !== 1'b1 ||
          empty !== 1'b1 || snoop_hit !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got count=%0d valid=%b ready=%b empty=%b hit=%b, expected 0 0 1 1 0",
                  count, mem_req_valid, evict_ready, empty, snoop_hit);
      end
      cyc();
      cyc();
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_push_ignored: got valid=%b, expected 0", mem_req_valid);
      end
      cyc();
   endtask

   initial begin
      test_reset();
      test_basic_push();
      test_zero_mask();
      test_fill_drain();
      test_simultaneous();
      test_snoop();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
